// File: rtl/cla_serial_adder_pkg.sv
// rtl/cla_serial_adder_pkg.sv - shared constants for the nibble-serial adder
package cla_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// rtl/cla_serial_adder_if.sv - operand/result handshake bundle for the serial adder
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_nibble_gp.sv
// rtl/cla_nibble_gp.sv - per-nibble generate/propagate and sum formation
module cla_nibble_gp (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic [3:0] carry,
  input  logic       carry_in,
  output logic [3:0] g4,
  output logic [3:0] p4,
  output logic [3:0] sum4
);

  assign g4 = a4 & b4;
  assign p4 = a4 | b4;
  // p is OR-based, so p^g recovers a^b before folding in the incoming carry
  assign sum4 = p4 ^ g4 ^ {carry[2:0], carry_in};

endmodule

// File: rtl/uat.sv
// rtl/uat.sv - 4-bit lookahead carry unit: carry vector from generate/propagate
module uat (
  input  logic [3:0] g_in,
  input  logic [3:0] p_in,
  input  logic       carry_in,
  output logic [3:0] carry
);

  assign carry[0] = g_in[0] | (p_in[0] & carry_in);
  assign carry[1] = g_in[1] | (p_in[1] & g_in[0]) | (p_in[1] & p_in[0] & carry_in);
  assign carry[2] = g_in[2] | (p_in[2] & g_in[1]) | (p_in[2] & p_in[1] & g_in[0])
                  | (p_in[2] & p_in[1] & p_in[0] & carry_in);
  assign carry[3] = g_in[3] | (p_in[3] & g_in[2]) | (p_in[3] & p_in[2] & g_in[1])
                  | (p_in[3] & p_in[2] & p_in[1] & g_in[0])
                  | (p_in[3] & p_in[2] & p_in[1] & p_in[0] & carry_in);

endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - nibble-serial add/subtract with valid/ready on both sides
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  cla_serial_adder_if.slave bus
);

  localparam int NIBBLES = nibble_count(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]                       state;
  logic [IDX_W-1:0]                 index;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] sum_q;
  logic                             carry_q;
  logic                             cout_q;
  logic                             ovf_q;
  logic [NIBBLE_W-1:0]              g;
  logic [NIBBLE_W-1:0]              p;
  logic [NIBBLE_W-1:0]              c;
  logic [NIBBLE_W-1:0]              s;

  cla_nibble_gp u_gp (
    .a4       (a_q[index]),
    .b4       (b_q[index]),
    .carry    (c),
    .carry_in (carry_q),
    .g4       (g),
    .p4       (p),
    .sum4     (s)
  );

  uat u_uat (
    .g_in     (g),
    .p_in     (p),
    .carry_in (carry_q),
    .carry    (c)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      index   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub | bus.cin;
            sum_q   <= '0;
            index   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[index] <= s;
          carry_q      <= c[3];
          // index returns to zero here so it is already clear when IDLE is reached
          if (index == LAST_IDX) begin
            cout_q <= c[3];
            ovf_q  <= c[2] ^ c[3];
            index  <= '0;
            state  <= DONE;
          end else begin
            index <= index + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - scoreboard bench for cla_serial_adder
module tb_cla_serial_adder;

  localparam int W       = 16;
  localparam int NIBBLES = W / 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  cla_serial_adder_if #(.WIDTH(W)) bus ();

  cla_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] bp;
    longint       c;
    longint       u;
    longint       s;
    bp = sub ? ~b : b;
    c  = (sub || cin) ? 1 : 0;
    u  = longint'(a) + longint'(bp) + c;
    e.sum  = u[W-1:0];
    e.cout = u[W];
    s = longint'($signed(a)) + longint'($signed(bp)) + c;
    e.ovf = (s > longint'(2**(W-1) - 1)) || (s < -longint'(2**(W-1)));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_ready && bus.out_valid) begin
        n_bad++;
        $display("FAIL ready_valid_exclusive: got both 1 expected never both");
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got sum 0x%0h expected no result", bus.sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", bus.sum, e.sum);
          check("cout", bus.cout, e.cout);
          check("ovf", bus.ovf, e.ovf);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input int stall);
    int           cyc;
    logic [W-1:0] held;
    bus.out_ready = (stall == 0);
    wait_ready();
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      return;
    end
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, cin, sub));
    #1;
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", bus.in_ready, 0);
    cyc = 0;
    // Scramble inputs and pulse in_valid while busy; none of it may be picked up.
    while (!bus.out_valid && cyc < 20) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a = W'($urandom); bus.b = W'($urandom);
      bus.cin = 1'($urandom); bus.sub = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("latency", cyc, NIBBLES);
    if (stall > 0) begin
      held = bus.sum;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_sum", bus.sum, held);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("in_ready_after_release", bus.in_ready, 1);
    check("out_valid_after_release", bus.out_valid, 0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 10);

    // Abort an operation two RUN cycles in; it must vanish without a result.
    wait_ready();
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", bus.in_ready, 1);
    check("midrun_rst_out_valid", bus.out_valid, 0);
    check("midrun_rst_sum", bus.sum, 0);
    check("midrun_rst_cout", bus.cout, 0);
    check("midrun_rst_ovf", bus.ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
